// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time and feeds IF/ID.
// Holds a returned word across a stall and discards the response of a redirected request.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  output logic [31:0] instr_cnt_o
);

  typedef enum logic [1:0] {StIdle, StReq, StHold, StDrop} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] hold_q;
  logic [31:0] redirect_q;
  logic [31:0] cnt_q;
  logic [31:0] target;
  logic        accept;

  assign target      = branch_target_i & ~32'h0000_0003;
  assign instr_cnt_o = cnt_q;
  assign accept      = valid_o & ~stall_i & ~flush_i;

  // Outputs are decoded from state; the REQ path forwards rdata combinationally so a
  // zero-wait memory sustains one instruction per cycle.
  always_comb begin
    imem_req_o  = 1'b0;
    imem_addr_o = 32'h0;
    valid_o     = 1'b0;
    instr_o     = 32'h0;
    pc_o        = 32'h0;
    unique case (state_q)
      StIdle: ;
      StReq: begin
        imem_req_o  = 1'b1;
        imem_addr_o = pc_q;
        if (imem_ack_i && !flush_i && !stall_i) begin
          valid_o = 1'b1;
          instr_o = imem_rdata_i;
          pc_o    = pc_q;
        end
      end
      StHold: begin
        if (!flush_i) begin
          valid_o = 1'b1;
          instr_o = hold_q;
          pc_o    = pc_q;
        end
      end
      StDrop: begin
        // The abandoned request keeps its address until the memory acks it.
        imem_req_o  = 1'b1;
        imem_addr_o = pc_q;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      hold_q     <= 32'h0;
      redirect_q <= 32'h0;
      cnt_q      <= 32'h0;
    end else begin
      if (accept) cnt_q <= cnt_q + 32'd1;
      unique case (state_q)
        StIdle: state_q <= StReq;
        StReq: begin
          if (imem_ack_i) begin
            if (flush_i) begin
              pc_q <= target;
            end else if (stall_i) begin
              hold_q  <= imem_rdata_i;
              state_q <= StHold;
            end else begin
              pc_q <= pc_q + 32'd4;
            end
          end else if (flush_i) begin
            redirect_q <= target;
            state_q    <= StDrop;
          end
        end
        StHold: begin
          if (flush_i) begin
            pc_q    <= target;
            state_q <= StReq;
          end else if (!stall_i) begin
            pc_q    <= pc_q + 32'd4;
            state_q <= StReq;
          end
        end
        StDrop: begin
          if (imem_ack_i) begin
            pc_q    <= flush_i ? target : redirect_q;
            state_q <= StReq;
          end else if (flush_i) begin
            redirect_q <= target;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: per-cycle vector table plus async-reset and PC-wrap
// sequences on a second instance built with RESET_PC at the top of the address space.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] target = 32'h0;
  logic        ack = 1'b0;
  logic [31:0] rdata = 32'h0;

  logic        req0, valid0, req1, valid1;
  logic [31:0] addr0, instr0, pc0, cnt0, addr1, instr1, pc1, cnt1;

  int applied = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut0 (
    .clk_i(clk), .start_i(start), .stall_i(stall), .flush_i(flush),
    .branch_target_i(target), .imem_req_o(req0), .imem_addr_o(addr0),
    .imem_ack_i(ack), .imem_rdata_i(rdata), .instr_o(instr0), .pc_o(pc0),
    .valid_o(valid0), .instr_cnt_o(cnt0)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk_i(clk), .start_i(start), .stall_i(stall), .flush_i(flush),
    .branch_target_i(target), .imem_req_o(req1), .imem_addr_o(addr1),
    .imem_ack_i(ack), .imem_rdata_i(rdata), .instr_o(instr1), .pc_o(pc1),
    .valid_o(valid1), .instr_cnt_o(cnt1)
  );

  typedef struct {
    logic        start, stall, flush, ack;
    logic [31:0] target, rdata;
    logic        ereq, evalid;
    logic [31:0] eaddr, einstr, epc, ecnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic st, logic sl, logic fl, logic ak, logic [31:0] tg,
                              logic [31:0] rd, logic rq, logic [31:0] ad, logic vl,
                              logic [31:0] in, logic [31:0] pc, logic [31:0] cn);
    vec_t v;
    v.start = st; v.stall = sl; v.flush = fl; v.ack = ak; v.target = tg; v.rdata = rd;
    v.ereq = rq; v.eaddr = ad; v.evalid = vl; v.einstr = in; v.epc = pc; v.ecnt = cn;
    return v;
  endfunction

  task automatic check(string name, bit sel, logic rq, logic [31:0] ad, logic vl,
                       logic [31:0] in, logic [31:0] pc, logic [31:0] cn);
    logic        a_rq, a_vl;
    logic [31:0] a_ad, a_in, a_pc, a_cn;
    if (sel) begin
      a_rq = req1; a_ad = addr1; a_vl = valid1; a_in = instr1; a_pc = pc1; a_cn = cnt1;
    end else begin
      a_rq = req0; a_ad = addr0; a_vl = valid0; a_in = instr0; a_pc = pc0; a_cn = cnt0;
    end
    applied++;
    if (a_rq !== rq || a_ad !== ad || a_vl !== vl || a_in !== in || a_pc !== pc
        || a_cn !== cn) begin
      miscompares++;
      $display("FAIL %s: got req=%b addr=%h valid=%b instr=%h pc=%h cnt=%0d, want req=%b addr=%h valid=%b instr=%h pc=%h cnt=%0d",
               name, a_rq, a_ad, a_vl, a_in, a_pc, a_cn, rq, ad, vl, in, pc, cn);
    end
  endtask

  task automatic drive(logic st, logic sl, logic fl, logic ak, logic [31:0] tg,
                       logic [31:0] rd);
    @(negedge clk);
    start = st; stall = sl; flush = fl; ack = ak; target = tg; rdata = rd;
    #1;
  endtask

  initial begin
    // start stall flush ack target rdata | req addr valid instr pc cnt
    tbl.push_back(mk(0,0,0,0, 32'h0,   32'h0,        0, 32'h0,   0, 32'h0,        32'h0,   0));
    tbl.push_back(mk(1,0,0,0, 32'h0,   32'h0,        0, 32'h0,   0, 32'h0,        32'h0,   0));
    tbl.push_back(mk(1,0,0,1, 32'h0,   32'h1111_1111, 1, 32'h0,  1, 32'h1111_1111, 32'h0,  0));
    tbl.push_back(mk(1,0,0,1, 32'h0,   32'h2222_2222, 1, 32'h4,  1, 32'h2222_2222, 32'h4,  1));
    tbl.push_back(mk(1,0,0,1, 32'h0,   32'h3333_3333, 1, 32'h8,  1, 32'h3333_3333, 32'h8,  2));
    tbl.push_back(mk(1,0,0,0, 32'h0,   32'h0,        1, 32'hC,   0, 32'h0,        32'h0,   3));
    // stall on ack -> HOLD for three cycles, consumed once
    tbl.push_back(mk(1,1,0,1, 32'h0,   32'h00A0_0093, 1, 32'hC,  0, 32'h0,        32'h0,   3));
    tbl.push_back(mk(1,1,0,0, 32'h0,   32'h0,        0, 32'h0,   1, 32'h00A0_0093, 32'hC,  3));
    tbl.push_back(mk(1,1,0,0, 32'h0,   32'h0,        0, 32'h0,   1, 32'h00A0_0093, 32'hC,  3));
    tbl.push_back(mk(1,1,0,0, 32'h0,   32'h0,        0, 32'h0,   1, 32'h00A0_0093, 32'hC,  3));
    tbl.push_back(mk(1,0,0,0, 32'h0,   32'h0,        0, 32'h0,   1, 32'h00A0_0093, 32'hC,  3));
    // flush while a 2-cycle request to 0x10 is pending
    tbl.push_back(mk(1,0,0,0, 32'h0,   32'h0,        1, 32'h10,  0, 32'h0,        32'h0,   4));
    tbl.push_back(mk(1,0,1,0, 32'h40,  32'h0,        1, 32'h10,  0, 32'h0,        32'h0,   4));
    tbl.push_back(mk(1,0,0,1, 32'h0,   32'hDEAD_BEEF, 1, 32'h10, 0, 32'h0,        32'h0,   4));
    // flush+stall with ack: flush wins, target low bits cleared
    tbl.push_back(mk(1,1,1,1, 32'h83,  32'h55,       1, 32'h40,  0, 32'h0,        32'h0,   4));
    tbl.push_back(mk(1,0,0,1, 32'h0,   32'h66,       1, 32'h80,  1, 32'h66,       32'h80,  4));
    // repeated flush while dropping: latest target wins
    tbl.push_back(mk(1,0,1,0, 32'h200, 32'h0,        1, 32'h84,  0, 32'h0,        32'h0,   5));
    tbl.push_back(mk(1,0,1,0, 32'h300, 32'h0,        1, 32'h84,  0, 32'h0,        32'h0,   5));
    tbl.push_back(mk(1,0,0,0, 32'h0,   32'h0,        1, 32'h84,  0, 32'h0,        32'h0,   5));
    tbl.push_back(mk(1,0,0,1, 32'h0,   32'hBAD0_0001, 1, 32'h84, 0, 32'h0,        32'h0,   5));
    tbl.push_back(mk(1,0,0,1, 32'h0,   32'h77,       1, 32'h300, 1, 32'h77,       32'h300, 5));
    // flush while holding: valid forced low, redirect to 0x43 -> 0x40
    tbl.push_back(mk(1,1,0,1, 32'h0,   32'h88,       1, 32'h304, 0, 32'h0,        32'h0,   6));
    tbl.push_back(mk(1,1,1,0, 32'h43,  32'h0,        0, 32'h0,   0, 32'h0,        32'h0,   6));
    tbl.push_back(mk(1,0,0,1, 32'h0,   32'h99,       1, 32'h40,  1, 32'h99,       32'h40,  6));
    // flush concurrent with the dropped ack takes the new target
    tbl.push_back(mk(1,0,1,0, 32'h500, 32'h0,        1, 32'h44,  0, 32'h0,        32'h0,   7));
    tbl.push_back(mk(1,0,1,1, 32'h600, 32'hBAD0_0002, 1, 32'h44, 0, 32'h0,        32'h0,   7));
    tbl.push_back(mk(1,0,0,0, 32'h0,   32'h0,        1, 32'h600, 0, 32'h0,        32'h0,   7));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].start, tbl[i].stall, tbl[i].flush, tbl[i].ack, tbl[i].target, tbl[i].rdata);
      check($sformatf("vec%0d", i), 1'b0, tbl[i].ereq, tbl[i].eaddr, tbl[i].evalid,
            tbl[i].einstr, tbl[i].epc, tbl[i].ecnt);
    end

    // Async reset mid-wait, between clock edges
    drive(1, 0, 0, 0, 32'h0, 32'h0);
    check("pre_reset", 1'b0, 1, 32'h600, 0, 32'h0, 32'h0, 7);
    #2 start = 1'b0;
    #1;
    check("async_reset", 1'b0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    check("async_reset_wrap", 1'b1, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    drive(1, 0, 0, 0, 32'h0, 32'h0);
    check("restart_idle", 1'b0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    drive(1, 0, 0, 0, 32'h0, 32'h0);
    check("restart_req", 1'b0, 1, 32'h0, 0, 32'h0, 32'h0, 0);
    check("wrap_req", 1'b1, 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0, 0);

    // PC wrap: accepted fetch at 0xFFFF_FFFC advances to 0
    drive(1, 0, 0, 1, 32'h0, 32'h0000_00AB);
    check("wrap_fetch", 1'b1, 1, 32'hFFFF_FFFC, 1, 32'h0000_00AB, 32'hFFFF_FFFC, 0);
    check("restart_fetch", 1'b0, 1, 32'h0, 1, 32'h0000_00AB, 32'h0, 0);
    drive(1, 0, 0, 0, 32'h0, 32'h0);
    check("wrap_next", 1'b1, 1, 32'h0, 0, 32'h0, 32'h0, 1);
    check("restart_next", 1'b0, 1, 32'h4, 0, 32'h0, 32'h0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
